// File: rtl/frame_sched_pkg.sv
// Shared types and defaults for the per-frame game-datapath scheduler.
package frame_sched_pkg;

  localparam int NUM_STAGES_DEF     = 4;
  localparam int TIMEOUT_CYCLES_DEF = 1_000_000;
  localparam int FC_W_DEF           = 16;

  localparam int OVR_DROP    = 0;
  localparam int OVR_TIMEOUT = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    SWAP  = 2'd3
  } state_t;

endpackage

// File: rtl/frame_scheduler_vsync_edge_detect.sv
// Synchronizes the async active-low vsync and emits a registered one-cycle
// tick on its falling edge. All history flops reset high so reset never looks like an edge.
module vsync_edge_detect (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_vsync,
  output logic o_frame_tick
);

  logic r_sync1, r_sync2, r_prev, r_tick;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
      r_tick  <= 1'b0;
    end else begin
      r_sync1 <= i_vsync;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_tick  <= r_prev & ~r_sync2;
    end
  end

  assign o_frame_tick = r_tick;

endmodule

// File: rtl/frame_scheduler.sv
// Runs the update stages once per vsync and swaps the display buffer at the end.
// Optional stage watchdog enabled by defining FRAME_SCHED_WATCHDOG_EN.
module frame_scheduler
  import frame_sched_pkg::*;
#(
  parameter int NUM_STAGES     = NUM_STAGES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int FC_W           = FC_W_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_vsync,
  input  logic                  i_pause,
  input  logic                  i_clr_status,
  input  logic [NUM_STAGES-1:0] i_stage_done,
  output logic [NUM_STAGES-1:0] o_stage_start,
  output logic                  o_busy,
  output logic                  o_swap,
  output logic                  o_buf_sel,
  output logic [FC_W-1:0]       o_frame_count,
  output logic [1:0]            o_overrun
);

  localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  state_t                  r_state;
  logic [IDX_W-1:0]        r_idx;
  logic [NUM_STAGES-1:0]   r_stage_start;
  logic                    r_busy, r_swap, r_buf_sel;
  logic [FC_W-1:0]         r_frame_count;
  logic [1:0]              r_overrun;
  logic                    w_frame_tick, w_done, w_timeout;

  vsync_edge_detect u_edge (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_vsync     (i_vsync),
    .o_frame_tick(w_frame_tick)
  );

  assign w_done = i_stage_done[r_idx];

`ifdef FRAME_SCHED_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] r_wdog;

  // Down-counter loaded in START; terminal count lands TIMEOUT_CYCLES cycles into WAIT.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      r_wdog <= '0;
    else if (r_state == START)
      r_wdog <= WD_W'(TIMEOUT_CYCLES);
    else if (r_state == WAIT && r_wdog != '0)
      r_wdog <= r_wdog - 1'b1;
  end

  assign w_timeout = (r_wdog == '0);
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= IDLE;
      r_idx         <= '0;
      r_stage_start <= '0;
      r_busy        <= 1'b0;
      r_swap        <= 1'b0;
      r_buf_sel     <= 1'b0;
      r_frame_count <= '0;
      r_overrun     <= '0;
    end else begin
      r_stage_start <= '0;
      r_swap        <= 1'b0;
      // Clear first so a same-cycle set below takes priority.
      if (i_clr_status)
        r_overrun <= '0;
      if (w_frame_tick && r_state != IDLE)
        r_overrun[OVR_DROP] <= 1'b1;

      case (r_state)
        IDLE: begin
          if (w_frame_tick && !i_pause) begin
            r_idx         <= '0;
            r_stage_start <= NUM_STAGES'(1);
            r_busy        <= 1'b1;
            r_state       <= START;
          end
        end
        START: r_state <= WAIT;
        WAIT: begin
          if (w_done || w_timeout) begin
            if (!w_done)
              r_overrun[OVR_TIMEOUT] <= 1'b1;
            if (r_idx == IDX_W'(NUM_STAGES - 1)) begin
              r_swap        <= 1'b1;
              r_buf_sel     <= ~r_buf_sel;
              r_frame_count <= r_frame_count + 1'b1;
              r_state       <= SWAP;
            end else begin
              r_idx         <= r_idx + 1'b1;
              r_stage_start <= NUM_STAGES'(1) << (r_idx + 1'b1);
              r_state       <= START;
            end
          end
        end
        SWAP: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_stage_start = r_stage_start;
  assign o_busy        = r_busy;
  assign o_swap        = r_swap;
  assign o_buf_sel     = r_buf_sel;
  assign o_frame_count = r_frame_count;
  assign o_overrun     = r_overrun;

endmodule
